audio_bus_master: RTL and testbench
===================================

// Module: audio_bus_master
// PURPOSE
//  Initiator side of the Computer_System external-bus-to-Avalon bridge (bus_master_audio
//  external interface). Takes stereo samples from the fabric (e.g. scaled Lorenz x/z
//  states from the DDA) and writes them into the audio core's left/right DAC FIFOs.
//  Before each stereo write it polls the FIFOSPACE register. It sits in the top level,
//  between the DDA datapath and the Computer_System bridge ports.
// PARAMETERS
//  BASE_ADDR   16'h3040  audio core base on bridge; +4 FIFOSPACE, +8 LEFTDATA, +12 RIGHTDATA
//  ADDR_W      16        bridge address width
//  DATA_W      32        bridge data width
//  POLL_GAP    4         idle cycles between FIFOSPACE polls when FIFO full (>=1)
//  TIMEOUT_CYC 1024      ack wait limit, cycles (only with ACK_TIMEOUT_EN)
// PORTS
//  clk             in   1       system clock, bridge clock domain
//  reset           in   1       async, active-high
//  sample_valid    in   1       stereo sample offered
//  sample_ready    out  1       block can accept a sample (1-deep buffer empty)
//  sample_left     in   DATA_W  left sample
//  sample_right    in   DATA_W  right sample
//  bus_addr        out  ADDR_W  to bridge address
//  bus_byte_enable out  4       to bridge byte_enable
//  bus_read        out  1       to bridge read
//  bus_write       out  1       to bridge write
//  bus_write_data  out  DATA_W  to bridge write_data
//  bus_ack         in   1       from bridge acknowledge
//  bus_read_data   in   DATA_W  from bridge read_data
//  samples_written out  32      count of completed stereo writes
//  timeout_err     out  1       1-cycle pulse on ack timeout
// BEHAVIOUR
//  - Reset values:
//    - all bus outputs 0, sample_ready 0 while reset asserted, then 1.
//    - samples_written 0; timeout_err 0; state IDLE; buffer empty.
//    - Reset mid-transaction drops the request immediately and discards the buffered sample.
//  - Sample capture and release:
//    - Capture on sample_valid & sample_ready; sample_ready drops the next cycle.
//    - sample_ready returns high the cycle after the RIGHT write's ack.
//  - Bus rules:
//    - At most one of read/write high; byte_enable always 4'hF while read or write high.
//    - addr, data and strobe are registered and held stable until bus_ack is sampled 1.
//    - Strobe deasserts the cycle after ack; a new request is no earlier than 1 cycle later.
//    - bus_read_data is sampled only on an ack cycle of a read.
//  - FSM:
//    - IDLE: buffer full -> POLL.
//    - POLL: read BASE_ADDR+4; on ack latch WSLC=rd[31:24], WSRC=rd[23:16] -> CHECK.
//    - CHECK: WSLC!=0 && WSRC!=0 -> WR_L; else -> WAIT.
//    - WAIT: count POLL_GAP cycles -> POLL.
//    - WR_L: write sample_left to BASE_ADDR+8; on ack -> WR_R.
//    - WR_R: write sample_right to BASE_ADDR+12; on ack:
//      - samples_written+1 (wraps 2^32-1 -> 0), buffer empty -> IDLE.
//  - Latency: sample capture to first strobe = 2 cycles (IDLE, POLL issue).
//  - Left/right are always written as a pair; no write is issued with WSLC or WSRC = 0.
//  - A sample_valid held while not ready is not captured; the source must hold its data.
// CONFIGURATION
//  - ACK_TIMEOUT_EN defined:
//    - Counter runs while a strobe is high.
//    - If TIMEOUT_CYC cycles pass without ack: strobe drops, timeout_err pulses 1 cycle,
//      FSM -> WAIT.
//    - The buffered sample is kept and the pair restarts from POLL (WR_L is reissued).
//  - ACK_TIMEOUT_EN undefined: waits for ack indefinitely; timeout_err tied 0; no counter.
// TESTING
//  - Reset, then one sample L=32'h0000_1234, R=32'hFFFF_8000; ack after 2 cycles and
//    FIFOSPACE=32'h8080_0000 -> read @0x3044, write 0x1234 @0x3048, write 0xFFFF8000
//    @0x304C; samples_written=1.
//  - FIFOSPACE=32'h0080_0000 three times, then 32'h0101_0000 -> three polls spaced by
//    POLL_GAP=4 idle cycles, no writes until the 4th poll, then exactly one L/R pair.
//  - Ack delayed 0, 1 and 7 cycles -> addr, data and strobe stable throughout; strobe
//    deasserts the cycle after ack; never read&write together.
//  - Assert reset during WR_L with ack never given -> bus_write=0 at once;
//    samples_written=0; sample_ready=1 after reset release.
//  - Preload samples_written=32'hFFFF_FFFF via forced writes, complete one pair -> wraps
//    to 0.
//  - ACK_TIMEOUT_EN, TIMEOUT_CYC=16, withhold ack on WR_L -> timeout_err pulses at cycle
//    16, re-poll, WR_L reissued; without the macro, the write stays asserted for >100
//    cycles.

Source files
------------

// File: rtl/audio_bus_master.sv
// audio_bus_master
// Initiator on the Computer_System external bus bridge that streams stereo
// samples into the audio core DAC FIFOs. Each buffered stereo sample is sent
// in three steps. First the FIFOSPACE register is polled. When both the left
// and the right write-space counts are nonzero, the left sample is written and
// then the right sample. When either FIFO is full, the block waits POLL_GAP
// cycles and polls again.
//
// Optional feature: define ACK_TIMEOUT_EN to abandon a request whose
// acknowledge has not arrived within TIMEOUT_CYC cycles. The FSM then backs off
// to WAIT and later restarts the pair from a fresh poll. The buffered sample is
// kept. Without the macro the block waits for an acknowledge indefinitely, and
// timeout_err is tied low.
module audio_bus_master #(
   parameter int                ADDR_W      = 16,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = 16'h3040,
   parameter int                DATA_W      = 32,
   parameter int                POLL_GAP    = 4,
   parameter int                TIMEOUT_CYC = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sample_valid,
   output logic              sample_ready,
   input  logic [DATA_W-1:0] sample_left,
   input  logic [DATA_W-1:0] sample_right,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [3:0]        bus_byte_enable,
   output logic              bus_read,
   output logic              bus_write,
   output logic [DATA_W-1:0] bus_write_data,
   input  logic              bus_ack,
   input  logic [DATA_W-1:0] bus_read_data,
   output logic [31:0]       samples_written,
   output logic              timeout_err
);

   typedef enum logic [2:0] {
      IDLE,
      POLL,
      CHECK,
      WAIT,
      WR_L,
      WR_R
   } state_t;

   localparam logic [ADDR_W-1:0] FifoSpaceAddr = BASE_ADDR + ADDR_W'(4);
   localparam logic [ADDR_W-1:0] LeftAddr      = BASE_ADDR + ADDR_W'(8);
   localparam logic [ADDR_W-1:0] RightAddr     = BASE_ADDR + ADDR_W'(12);
   localparam int                GapW          = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
   localparam logic [GapW-1:0]   GapLast       = GapW'(POLL_GAP - 1);

   state_t            r_state;
   state_t            w_stateNext;
   logic              r_alive;
   logic              r_bufFull;
   logic [DATA_W-1:0] r_left;
   logic [DATA_W-1:0] r_right;
   logic              r_read;
   logic              r_write;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [7:0]        r_wslc;
   logic [7:0]        r_wsrc;
   logic [GapW-1:0]   r_gapCnt;
   logic [31:0]       r_samplesWritten;

   logic              w_readNext;
   logic              w_writeNext;
   logic [ADDR_W-1:0] w_addrNext;
   logic [DATA_W-1:0] w_wdataNext;
   logic [7:0]        w_wslcNext;
   logic [7:0]        w_wsrcNext;
   logic [GapW-1:0]   w_gapNext;
   logic [31:0]       w_countNext;
   logic              w_bufRelease;
   logic              w_ready;
   logic              w_capture;
   logic [15:0]       w_unusedRdBits;

   assign w_ready        = r_alive & ~r_bufFull;
   assign w_capture      = sample_valid & w_ready;
   assign w_unusedRdBits = bus_read_data[15:0];

`ifdef ACK_TIMEOUT_EN
   localparam int             ToW    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_CYC - 1);

   logic [ToW-1:0] r_toCnt;
   logic           r_timeoutErr;
   logic           w_toFire;

   assign w_toFire = (r_read | r_write) & ~bus_ack & (r_toCnt == ToLast);

   // Count the cycles an outstanding strobe has waited, and flag the cycle it gives up
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_toCnt      <= '0;
         r_timeoutErr <= 1'b0;
      end else begin
         r_timeoutErr <= w_toFire;
         if (!(r_read | r_write) || bus_ack || w_toFire) begin
            r_toCnt <= '0;
         end else begin
            r_toCnt <= r_toCnt + ToW'(1);
         end
      end
   end

   assign timeout_err = r_timeoutErr;
`else
   logic [31:0] w_unusedTimeout;
   assign w_unusedTimeout = 32'(TIMEOUT_CYC);
   assign timeout_err     = 1'b0;
`endif

   // Sequence poll / decide / back-off / left write / right write and compute the next bus request
   always_comb begin
      w_stateNext  = r_state;
      w_readNext   = r_read;
      w_writeNext  = r_write;
      w_addrNext   = r_addr;
      w_wdataNext  = r_wdata;
      w_wslcNext   = r_wslc;
      w_wsrcNext   = r_wsrc;
      w_gapNext    = r_gapCnt;
      w_countNext  = r_samplesWritten;
      w_bufRelease = 1'b0;

      case (r_state)
         IDLE: begin
            if (r_bufFull) begin
               w_stateNext = POLL;
            end
         end
         POLL: begin
            if (!r_read) begin
               w_readNext = 1'b1;
               w_addrNext = FifoSpaceAddr;
            end else if (bus_ack) begin
               w_readNext  = 1'b0;
               w_addrNext  = '0;
               w_wslcNext  = bus_read_data[31:24];
               w_wsrcNext  = bus_read_data[23:16];
               w_stateNext = CHECK;
            end
         end
         CHECK: begin
            if ((r_wslc != 8'd0) && (r_wsrc != 8'd0)) begin
               w_stateNext = WR_L;
            end else begin
               w_gapNext   = '0;
               w_stateNext = WAIT;
            end
         end
         WAIT: begin
            if (r_gapCnt == GapLast) begin
               w_gapNext   = '0;
               w_stateNext = POLL;
            end else begin
               w_gapNext = r_gapCnt + GapW'(1);
            end
         end
         WR_L: begin
            if (!r_write) begin
               w_writeNext = 1'b1;
               w_addrNext  = LeftAddr;
               w_wdataNext = r_left;
            end else if (bus_ack) begin
               w_writeNext = 1'b0;
               w_addrNext  = '0;
               w_wdataNext = '0;
               w_stateNext = WR_R;
            end
         end
         WR_R: begin
            if (!r_write) begin
               w_writeNext = 1'b1;
               w_addrNext  = RightAddr;
               w_wdataNext = r_right;
            end else if (bus_ack) begin
               w_writeNext  = 1'b0;
               w_addrNext   = '0;
               w_wdataNext  = '0;
               w_countNext  = r_samplesWritten + 32'd1;
               w_bufRelease = 1'b1;
               w_stateNext  = IDLE;
            end
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase

`ifdef ACK_TIMEOUT_EN
      if (w_toFire) begin
         w_readNext  = 1'b0;
         w_writeNext = 1'b0;
         w_addrNext  = '0;
         w_wdataNext = '0;
         w_gapNext   = '0;
         w_stateNext = WAIT;
      end
`endif
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Registered bus request, FIFOSPACE snapshot, back-off counter and pair counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_read           <= 1'b0;
         r_write          <= 1'b0;
         r_addr           <= '0;
         r_wdata          <= '0;
         r_wslc           <= '0;
         r_wsrc           <= '0;
         r_gapCnt         <= '0;
         r_samplesWritten <= '0;
      end else begin
         r_read           <= w_readNext;
         r_write          <= w_writeNext;
         r_addr           <= w_addrNext;
         r_wdata          <= w_wdataNext;
         r_wslc           <= w_wslcNext;
         r_wsrc           <= w_wsrcNext;
         r_gapCnt         <= w_gapNext;
         r_samplesWritten <= w_countNext;
      end
   end

   // One-deep stereo sample buffer; ready stays low until the first clock after reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_alive   <= 1'b0;
         r_bufFull <= 1'b0;
         r_left    <= '0;
         r_right   <= '0;
      end else begin
         r_alive <= 1'b1;
         if (w_bufRelease) begin
            r_bufFull <= 1'b0;
         end else if (w_capture) begin
            r_bufFull <= 1'b1;
            r_left    <= sample_left;
            r_right   <= sample_right;
         end
      end
   end

   assign sample_ready    = w_ready;
   assign bus_read        = r_read;
   assign bus_write       = r_write;
   assign bus_addr        = r_addr;
   assign bus_write_data  = r_wdata;
   assign bus_byte_enable = (r_read | r_write) ? 4'hF : 4'h0;
   assign samples_written = r_samplesWritten;

endmodule

// File: tb/tb_audio_bus_master.sv
// tb_audio_bus_master
// Directed bench for audio_bus_master. The bench acts as the bridge slave. A
// table of stereo samples, FIFOSPACE replies and acknowledge delays is played
// through the design. Hand-written sequences then cover these cases:
//   - reset in the middle of a write;
//   - wrap-around of the pair counter;
//   - an acknowledge that is withheld. This exercises the ACK_TIMEOUT_EN
//     behaviour when the macro is defined, and the indefinite wait when it is
//     not.
`timescale 1ns/1ps
module tb_audio_bus_master;

   localparam int          PollGap    = 4;
   localparam int          TimeoutCyc = 16;
   localparam logic [15:0] PollAddr   = 16'h3044;
   localparam logic [15:0] LeftAddr   = 16'h3048;
   localparam logic [15:0] RightAddr  = 16'h304C;
   localparam logic [31:0] Junk       = 32'hFFFF_FFFF;

   typedef struct {
      logic [31:0] left;
      logic [31:0] right;
      int          fullPolls;
      logic [31:0] fullSpace;
      logic [31:0] okSpace;
      int          ackDelay;
      logic [31:0] expCount;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        sample_valid = 1'b0;
   logic        sample_ready;
   logic [31:0] sample_left = '0;
   logic [31:0] sample_right = '0;
   logic [15:0] bus_addr;
   logic [3:0]  bus_byte_enable;
   logic        bus_read;
   logic        bus_write;
   logic [31:0] bus_write_data;
   logic        bus_ack = 1'b0;
   logic [31:0] bus_read_data = Junk;
   logic [31:0] samples_written;
   logic        timeout_err;

   int testsRun = 0;
   int testsFailed = 0;
   vec_t vecs[4];

   audio_bus_master #(
      .ADDR_W     (16),
      .BASE_ADDR  (16'h3040),
      .DATA_W     (32),
      .POLL_GAP   (PollGap),
      .TIMEOUT_CYC(TimeoutCyc)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .sample_valid   (sample_valid),
      .sample_ready   (sample_ready),
      .sample_left    (sample_left),
      .sample_right   (sample_right),
      .bus_addr       (bus_addr),
      .bus_byte_enable(bus_byte_enable),
      .bus_read       (bus_read),
      .bus_write      (bus_write),
      .bus_write_data (bus_write_data),
      .bus_ack        (bus_ack),
      .bus_read_data  (bus_read_data),
      .samples_written(samples_written),
      .timeout_err    (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Offer one stereo sample for exactly one cycle, then scramble the data lines
   task automatic applyStimulus(input logic [31:0] left, input logic [31:0] right, input string tag);
      int n;
      n = 0;
      while (!sample_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput({tag, "ReadyIn"}, 32'(sample_ready), 32'd1);
      sample_valid = 1'b1;
      sample_left  = left;
      sample_right = right;
      @(negedge clk);
      sample_valid = 1'b0;
      sample_left  = ~left;
      sample_right = ~right;
      checkOutput({tag, "ReadyDrop"}, 32'(sample_ready), 32'd0);
   endtask

   // Act as the bridge slave for one expected request; 'waited' is the number of strobe-low cycles seen first
   task automatic serveTxn(input logic expRead, input logic [15:0] expAddr, input logic [31:0] expData,
                           input int ackDelay, input logic [31:0] rdData, input string tag, output int waited);
      waited = 0;
      while (!(bus_read || bus_write) && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      checkOutput({tag, "Strobe"}, 32'(bus_read | bus_write), 32'd1);
      checkOutput({tag, "Read"}, 32'(bus_read), 32'(expRead));
      checkOutput({tag, "Write"}, 32'(bus_write), 32'(!expRead));
      checkOutput({tag, "Addr"}, 32'(bus_addr), 32'(expAddr));
      checkOutput({tag, "Be"}, 32'(bus_byte_enable), 32'hF);
      if (!expRead) checkOutput({tag, "Data"}, bus_write_data, expData);
      for (int d = 0; d < ackDelay; d++) begin
         @(negedge clk);
         checkOutput({tag, "HoldRead"}, 32'(bus_read), 32'(expRead));
         checkOutput({tag, "HoldWrite"}, 32'(bus_write), 32'(!expRead));
         checkOutput({tag, "HoldAddr"}, 32'(bus_addr), 32'(expAddr));
         if (!expRead) checkOutput({tag, "HoldData"}, bus_write_data, expData);
      end
      bus_ack = 1'b1;
      bus_read_data = expRead ? rdData : Junk;
      @(negedge clk);
      bus_ack = 1'b0;
      bus_read_data = Junk;
      checkOutput({tag, "Drop"}, 32'(bus_read | bus_write), 32'd0);
   endtask

   // Run one table record: poll until space, then the left/right pair
   task automatic runPair(input vec_t v, input string tag);
      int waited;
      applyStimulus(v.left, v.right, tag);
      for (int p = 0; p <= v.fullPolls; p++) begin
         serveTxn(1'b1, PollAddr, 32'h0, v.ackDelay, (p < v.fullPolls) ? v.fullSpace : v.okSpace,
                  {tag, "Poll"}, waited);
         if (p == 0) begin
            checkOutput({tag, "Latency"}, 32'(waited), 32'd2);
         end else begin
            // CHECK decode cycle + POLL_GAP back-off cycles + POLL issue cycle
            checkOutput({tag, "PollGap"}, 32'(waited), 32'(PollGap + 2));
         end
      end
      serveTxn(1'b0, LeftAddr, v.left, v.ackDelay, Junk, {tag, "WrL"}, waited);
      checkOutput({tag, "GapL"}, 32'(waited), 32'd2);
      serveTxn(1'b0, RightAddr, v.right, v.ackDelay, Junk, {tag, "WrR"}, waited);
      checkOutput({tag, "GapR"}, 32'(waited), 32'd1);
      checkOutput({tag, "ReadyBack"}, 32'(sample_ready), 32'd1);
      checkOutput({tag, "Count"}, samples_written, v.expCount);
   endtask

   // Wait for the left write to appear without acknowledging it
   task automatic waitForLeftWrite(input string tag);
      int n;
      n = 0;
      while (!bus_write && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput({tag, "WrLUp"}, 32'(bus_write), 32'd1);
      checkOutput({tag, "WrLAddr"}, 32'(bus_addr), 32'(LeftAddr));
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, got running, expected finished");
      $fatal(1);
   end

   initial begin
      int waited;
      int cnt;

      vecs[0] = '{32'h0000_1234, 32'hFFFF_8000, 0, 32'h0000_0000, 32'h8080_0000, 2, 32'd1};
      vecs[1] = '{32'hA5A5_0001, 32'h5A5A_0002, 3, 32'h0080_0000, 32'h0101_0000, 0, 32'd2};
      vecs[2] = '{32'h7FFF_FFFF, 32'h8000_0001, 1, 32'h8000_0000, 32'h0101_0000, 1, 32'd3};
      vecs[3] = '{32'hDEAD_0000, 32'h0000_BEEF, 0, 32'h0000_0000, 32'hFF01_0000, 7, 32'd4};

      repeat (3) @(negedge clk);
      checkOutput("rstRead", 32'(bus_read), 32'd0);
      checkOutput("rstWrite", 32'(bus_write), 32'd0);
      checkOutput("rstAddr", 32'(bus_addr), 32'd0);
      checkOutput("rstBe", 32'(bus_byte_enable), 32'd0);
      checkOutput("rstData", bus_write_data, 32'd0);
      checkOutput("rstReady", 32'(sample_ready), 32'd0);
      checkOutput("rstCount", samples_written, 32'd0);
      checkOutput("rstTimeout", 32'(timeout_err), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("rstReadyAfter", 32'(sample_ready), 32'd1);

      for (int i = 0; i < 4; i++) begin
         runPair(vecs[i], $sformatf("vec%0d", i));
      end

      cnt = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bus_read || bus_write) cnt++;
      end
      checkOutput("idleNoStrobe", 32'(cnt), 32'd0);

      // Reset while the left write is outstanding
      applyStimulus(32'h1111_2222, 32'h3333_4444, "rstMid");
      serveTxn(1'b1, PollAddr, 32'h0, 0, 32'h0101_0000, "rstMidPoll", waited);
      waitForLeftWrite("rstMid");
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      checkOutput("rstMidWrite", 32'(bus_write), 32'd0);
      checkOutput("rstMidAddr", 32'(bus_addr), 32'd0);
      checkOutput("rstMidCount", samples_written, 32'd0);
      checkOutput("rstMidReady", 32'(sample_ready), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("rstMidReadyAfter", 32'(sample_ready), 32'd1);
      cnt = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bus_read || bus_write) cnt++;
      end
      checkOutput("rstMidDiscard", 32'(cnt), 32'd0);

      // Pair counter wrap from all ones
      force dut.r_samplesWritten = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.r_samplesWritten;
      @(negedge clk);
      checkOutput("wrapPreload", samples_written, 32'hFFFF_FFFF);
      runPair('{32'h0000_0042, 32'h0000_0043, 0, 32'h0, 32'h0202_0000, 1, 32'd0}, "wrap");

      // Left write acknowledge withheld
      applyStimulus(32'hCAFE_0001, 32'hCAFE_0002, "noAck");
      serveTxn(1'b1, PollAddr, 32'h0, 0, 32'h0101_0000, "noAckPoll", waited);
      waitForLeftWrite("noAck");
`ifdef ACK_TIMEOUT_EN
      cnt = 0;
      while (bus_write && cnt < 100) begin
         if (timeout_err) cnt = cnt + 1000;
         @(negedge clk);
         cnt++;
      end
      checkOutput("toHighCycles", 32'(cnt), 32'(TimeoutCyc));
      checkOutput("toPulse", 32'(timeout_err), 32'd1);
      @(negedge clk);
      checkOutput("toPulseEnd", 32'(timeout_err), 32'd0);
      serveTxn(1'b1, PollAddr, 32'h0, 0, 32'h0101_0000, "toRepoll", waited);
      // POLL_GAP back-off cycles + POLL issue cycle, minus the one already observed
      checkOutput("toRepollGap", 32'(waited), 32'(PollGap));
      serveTxn(1'b0, LeftAddr, 32'hCAFE_0001, 0, Junk, "toWrL", waited);
      serveTxn(1'b0, RightAddr, 32'hCAFE_0002, 0, Junk, "toWrR", waited);
`else
      cnt = 0;
      for (int c = 0; c < 120; c++) begin
         @(negedge clk);
         if (bus_write && !timeout_err && bus_addr == LeftAddr) cnt++;
      end
      checkOutput("noToHeld", 32'(cnt), 32'd120);
      serveTxn(1'b0, LeftAddr, 32'hCAFE_0001, 0, Junk, "noToWrL", waited);
      serveTxn(1'b0, RightAddr, 32'hCAFE_0002, 0, Junk, "noToWrR", waited);
`endif
      checkOutput("noAckCount", samples_written, 32'd1);
      checkOutput("noAckReady", 32'(sample_ready), 32'd1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
